// File: rtl/kbd_event_sched.sv
// kbd_event_sched: decodes latched PS/2 code words into per-player command FIFOs and a key-held bitmap.
// Define KBD_TYPEMATIC_FILTER_EN to discard repeated makes of keys that are already held.
module kbd_event_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        counter_reset,
  input  logic        keycode_valid,
  input  logic [23:0] keycode_in,
  output logic        keycode_clr,
  output logic        p0_valid,
  output logic        p1_valid,
  input  logic        p0_ready,
  input  logic        p1_ready,
  output logic [3:0]  p0_evt,
  output logic [3:0]  p1_evt,
  output logic [9:0]  held,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE, DECODE} state_t;

  state_t        state_q, state_d;
  logic          keycode_clr_q, keycode_clr_d;
  logic [23:0]   word_q, word_d;
  logic [9:0]    held_q, held_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [3:0]    mem_q [2][FIFO_DEPTH];
  logic [3:0]    mem_d [2][FIFO_DEPTH];

  logic       decode_en;
  logic       is_break;
  logic       is_ext;
  logic       mapped;
  logic       map_player;
  logic [2:0] map_cmd;
  logic [3:0] held_idx;
  logic       filtered;
  logic       push_req;
  logic       push_ok;
  logic       drop_evt;
  logic [1:0] empty;
  logic [1:0] full;
  logic [1:0] pop;

  always_ff @(posedge clk or posedge counter_reset) begin
    if (counter_reset) begin
      state_q       <= IDLE;
      keycode_clr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      keycode_clr_q <= keycode_clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (keycode_valid) begin
          state_d = DECODE;
          word_d  = keycode_in;
        end
      end
      DECODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // keycode_clr is registered off the next state so it covers exactly the DECODE cycle
  always_comb begin
    decode_en     = (state_q == DECODE);
    keycode_clr_d = (state_d == DECODE);
  end

  always_comb begin
    is_break   = (word_q[15:8] == 8'hF0);
    is_ext     = (word_q[15:8] == 8'hE0) || (is_break && (word_q[23:16] == 8'hE0));
    mapped     = 1'b1;
    map_player = 1'b0;
    map_cmd    = 3'd0;
    if (is_ext) begin
      map_player = 1'b1;
      case (word_q[7:0])
        8'h75:   map_cmd = 3'd0;
        8'h6B:   map_cmd = 3'd1;
        8'h72:   map_cmd = 3'd2;
        8'h74:   map_cmd = 3'd3;
        default: mapped  = 1'b0;
      endcase
    end else begin
      case (word_q[7:0])
        8'h1D:   map_cmd = 3'd0;
        8'h1C:   map_cmd = 3'd1;
        8'h1B:   map_cmd = 3'd2;
        8'h23:   map_cmd = 3'd3;
        8'h29:   map_cmd = 3'd4;
        8'h5A: begin
          map_player = 1'b1;
          map_cmd    = 3'd4;
        end
        default: mapped = 1'b0;
      endcase
    end
    held_idx = map_player ? (4'd5 + {1'b0, map_cmd}) : {1'b0, map_cmd};
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  assign filtered = mapped && !is_break && held_q[held_idx];
`else
  assign filtered = 1'b0;
`endif

  // Fullness is judged before this cycle's pop, so a push into a full FIFO drops even while it pops
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
    pop[0]   = p0_ready && !empty[0];
    pop[1]   = p1_ready && !empty[1];
    push_req = decode_en && mapped && !filtered;
    push_ok  = push_req && !full[map_player];
    drop_evt = decode_en && (!mapped || (push_req && full[map_player]));
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_d[i][j] = mem_q[i][j];
      end
    end
    if (push_ok) begin
      mem_d[map_player][wr_ptr_q[map_player][AW-1:0]] = {is_break, map_cmd};
      wr_ptr_d[map_player] = wr_ptr_q[map_player] + PW'(1);
    end
  end

  always_comb begin
    held_d     = held_q;
    drop_cnt_d = drop_cnt_q;
    if (push_req) begin
      held_d[held_idx] = !is_break;
    end
    if (drop_evt && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge counter_reset) begin
    if (counter_reset) begin
      word_q     <= '0;
      held_q     <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      word_q     <= word_d;
      held_q     <= held_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign keycode_clr = keycode_clr_q;
  assign p0_valid    = !empty[0];
  assign p1_valid    = !empty[1];
  assign p0_evt      = mem_q[0][rd_ptr_q[0][AW-1:0]];
  assign p1_evt      = mem_q[1][rd_ptr_q[1][AW-1:0]];
  assign held        = held_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_kbd_event_sched.sv
// Scoreboard bench for kbd_event_sched: a table-driven key model predicts FIFO contents,
// held bits and drop count; a negedge monitor pops and compares the player FIFO heads.
module tb_kbd_event_sched;
  localparam int DEPTH = 4;
`ifdef KBD_TYPEMATIC_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam logic [7:0] P0_CODES [5]     = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29};
  localparam logic [7:0] P1_EXT_CODES [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};

  logic        clk = 1'b0;
  logic        counter_reset;
  logic        keycode_valid;
  logic [23:0] keycode_in;
  logic        keycode_clr;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [3:0]  p0_evt, p1_evt;
  logic [9:0]  held;
  logic [7:0]  drop_cnt;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic [9:0] held_m;
  int         drops_m;
  bit [1:0]   pop_now;

  kbd_event_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .counter_reset(counter_reset),
    .keycode_valid(keycode_valid),
    .keycode_in(keycode_in),
    .keycode_clr(keycode_clr),
    .p0_valid(p0_valid),
    .p1_valid(p1_valid),
    .p0_ready(p0_ready),
    .p1_ready(p1_ready),
    .p0_evt(p0_evt),
    .p1_evt(p1_evt),
    .held(held),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: inputs settle at posedge+1, so the negedge sees what the next edge will act on
  always @(negedge clk) begin
    pop_now = 2'b00;
    if (!counter_reset) begin
      check_val("p0_valid", 32'(p0_valid), 32'(exp_q0.size() != 0));
      if (exp_q0.size() != 0 && p0_ready) begin
        pop_now[0] = 1'b1;
        check_val("p0_evt", 32'(p0_evt), 32'(exp_q0.pop_front()));
      end
      check_val("p1_valid", 32'(p1_valid), 32'(exp_q1.size() != 0));
      if (exp_q1.size() != 0 && p1_ready) begin
        pop_now[1] = 1'b1;
        check_val("p1_evt", 32'(p1_evt), 32'(exp_q1.pop_front()));
      end
    end
  end

  task automatic model_decode(input logic [23:0] w);
    bit brk, ext, mapped;
    int pl, cmd, idx, occ;
    brk    = (w[15:8] == 8'hF0);
    ext    = (w[15:8] == 8'hE0) || (brk && w[23:16] == 8'hE0);
    mapped = 1'b0;
    pl     = 0;
    cmd    = 0;
    for (int i = 0; i < 5; i++) begin
      if (!ext && w[7:0] == P0_CODES[i]) begin
        mapped = 1'b1; pl = 0; cmd = i;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ext && w[7:0] == P1_EXT_CODES[i]) begin
        mapped = 1'b1; pl = 1; cmd = i;
      end
    end
    if (!ext && w[7:0] == 8'h5A) begin
      mapped = 1'b1; pl = 1; cmd = 4;
    end
    if (!mapped) begin
      if (drops_m < 255) drops_m++;
      return;
    end
    idx = pl * 5 + cmd;
    if (FILTER && !brk && held_m[idx]) return;
    held_m[idx] = !brk;
    occ = ((pl == 1) ? exp_q1.size() : exp_q0.size()) + int'(pop_now[pl]);
    if (occ >= DEPTH) begin
      if (drops_m < 255) drops_m++;
    end else if (pl == 1) begin
      exp_q1.push_back({brk, 3'(cmd)});
    end else begin
      exp_q0.push_back({brk, 3'(cmd)});
    end
  endtask

  task automatic checkOutput(input string tag);
    check_val({tag, ":keycode_clr"}, 32'(keycode_clr), 32'd0);
    check_val({tag, ":held"}, 32'(held), 32'(held_m));
    check_val({tag, ":drop_cnt"}, 32'(drop_cnt), 32'(drops_m));
    check_val({tag, ":p0_valid"}, 32'(p0_valid), 32'(exp_q0.size() != 0));
    check_val({tag, ":p1_valid"}, 32'(p1_valid), 32'(exp_q1.size() != 0));
  endtask

  // One key: capture cycle with ready rc, DECODE cycle with ready rd
  task automatic applyStimulus(input logic [23:0] word, input logic [1:0] rc, input logic [1:0] rd);
    keycode_valid = 1'b1;
    keycode_in    = word;
    {p1_ready, p0_ready} = rc;
    @(posedge clk); #1;
    check_val("keycode_clr_decode", 32'(keycode_clr), 32'd1);
    keycode_valid = 1'b0;
    {p1_ready, p0_ready} = rd;
    @(negedge clk); #1;
    model_decode(word);
    @(posedge clk); #1;
    checkOutput("after_decode");
  endtask

  task automatic idle(input int n, input logic [1:0] r);
    repeat (n) begin
      {p1_ready, p0_ready} = r;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    held_m  = '0;
    drops_m = 0;
  endtask

  task automatic do_reset();
    counter_reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    counter_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] w;
    logic [7:0]  c;
    int          r, k;
    bit          b, e;

    counter_reset = 1'b1;
    keycode_valid = 1'b0;
    keycode_in    = '0;
    p0_ready      = 1'b0;
    p1_ready      = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    counter_reset = 1'b0;
    idle(1, 2'b00);

    $display("[TB] single UP make for player 0");
    applyStimulus(24'h00001D, 2'b00, 2'b00);
    idle(2, 2'b11);

    $display("[TB] extended make then break for player 1");
    applyStimulus(24'h00E075, 2'b00, 2'b00);
    applyStimulus(24'hE0F075, 2'b00, 2'b00);
    idle(3, 2'b11);

    $display("[TB] five FIRE makes into a stalled FIFO");
    for (int i = 0; i < 5; i++) applyStimulus(24'h000029, 2'b00, 2'b00);
    idle(DEPTH + 1, 2'b11);

    $display("[TB] unmapped code saturates drop counter");
    for (int i = 0; i < 300; i++) applyStimulus(24'h000015, 2'b00, 2'b00);

    $display("[TB] reset asserted during DECODE");
    applyStimulus(24'h00001C, 2'b00, 2'b00);
    applyStimulus(24'h00E06B, 2'b00, 2'b00);
    keycode_valid = 1'b1;
    keycode_in    = 24'h00001B;
    @(posedge clk); #1;
    check_val("keycode_clr_before_reset", 32'(keycode_clr), 32'd1);
    keycode_valid = 1'b0;
    counter_reset = 1'b1;
    #1;
    check_val("rst_keycode_clr", 32'(keycode_clr), 32'd0);
    check_val("rst_p0_valid", 32'(p0_valid), 32'd0);
    check_val("rst_p1_valid", 32'(p1_valid), 32'd0);
    check_val("rst_held", 32'(held), 32'd0);
    check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    clear_model();
    #1 counter_reset = 1'b0;
    idle(3, 2'b11);
    checkOutput("post_reset");

    $display("[TB] keycode_valid held across reset release is re-captured");
    {p1_ready, p0_ready} = 2'b00;
    keycode_valid = 1'b1;
    keycode_in    = 24'h00001D;
    counter_reset = 1'b1;
    clear_model();
    #1 counter_reset = 1'b0;
    @(posedge clk); #1;
    check_val("recapture_keycode_clr", 32'(keycode_clr), 32'd1);
    keycode_valid = 1'b0;
    @(negedge clk); #1;
    model_decode(24'h00001D);
    @(posedge clk); #1;
    checkOutput("recapture");
    idle(3, 2'b11);

    $display("[TB] push into full FIFO while it pops");
    do_reset();
    applyStimulus(24'h00001D, 2'b00, 2'b00);
    applyStimulus(24'h00001C, 2'b00, 2'b00);
    applyStimulus(24'h00001B, 2'b00, 2'b00);
    applyStimulus(24'h000023, 2'b00, 2'b00);
    applyStimulus(24'h000029, 2'b00, 2'b01);
    check_val("full_pop_drop_cnt", 32'(drop_cnt), 32'd1);
    idle(DEPTH + 1, 2'b11);

    $display("[TB] randomized key stream");
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        k = int'($urandom_range(0, 9));
        b = 1'($urandom_range(0, 1));
        if (k < 5) begin
          c = P0_CODES[k]; e = 1'b0;
        end else if (k < 9) begin
          c = P1_EXT_CODES[k - 5]; e = 1'b1;
        end else begin
          c = 8'h5A; e = 1'b0;
        end
        if (e) w = b ? {8'hE0, 8'hF0, c} : {8'h00, 8'hE0, c};
        else   w = b ? {8'h00, 8'hF0, c} : {16'h0000, c};
      end else begin
        w = 24'($urandom);
      end
      applyStimulus(w, 2'($urandom), 2'($urandom));
      idle(int'($urandom_range(0, 2)), 2'($urandom));
    end
    idle(2 * DEPTH + 2, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
